// File: rtl/at_pkg.sv
// Shared constants and types for the AT capture/drain blocks.
package at_pkg;

    localparam int AT_DATA_W      = 8;
    localparam int AT_DRAIN_DEPTH = 4;
    localparam int AT_PTR_W       = $clog2(AT_DRAIN_DEPTH);

    typedef logic [AT_DATA_W-1:0] at_word_t;

endpackage : at_pkg

// File: rtl/at_drain_mem.sv
// Register-array storage for the drain FIFO: one write port, asynchronous read.
module at_drain_mem
    import at_pkg::*;
#(
    parameter int size  = AT_DATA_W,
    parameter int depth = AT_DRAIN_DEPTH,
    parameter int ptr_w = AT_PTR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ptr_w-1:0] waddr,
    input  logic [size-1:0]  wdata,
    input  logic [ptr_w-1:0] raddr,
    output logic [size-1:0]  rdata
);

    logic [size-1:0] mem_q [depth];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : at_drain_mem

// File: rtl/at_latch_drain.sv
// Strobe-captured words buffered in a small FIFO and drained over valid/ready.
// Optional sticky overflow flag enabled by defining AT_LATCH_DRAIN_OVFL_EN.
module at_latch_drain
    import at_pkg::*;
#(
    parameter int size  = AT_DATA_W,
    parameter int depth = AT_DRAIN_DEPTH,
    parameter int ptr_w = AT_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e,
    input  logic [size-1:0]  d,
    output logic             full,
    output logic [size-1:0]  q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [ptr_w:0]   count,
    output logic             ovfl
);

    localparam logic [ptr_w-1:0] PTR_ONE   = {{(ptr_w-1){1'b0}}, 1'b1};
    localparam logic [ptr_w:0]   CNT_ONE   = {{ptr_w{1'b0}}, 1'b1};
    localparam logic [ptr_w:0]   CNT_DEPTH = (ptr_w+1)'(depth);

    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]   count_q,  count_d;
    logic             push_s, pop_s;
    logic [size-1:0]  rdata_s;

    assign full    = (count_q == CNT_DEPTH);
    assign q_valid = (count_q != {(ptr_w+1){1'b0}});
    assign count   = count_q;
    assign pop_s   = q_valid && q_ready;
    assign push_s  = e && (!full || pop_s);
    assign q       = q_valid ? rdata_s : {size{1'b0}};

    at_drain_mem #(
        .size  (size),
        .depth (depth),
        .ptr_w (ptr_w)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (d),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {ptr_w{1'b0}};
            rd_ptr_q <= {ptr_w{1'b0}};
            count_q  <= {(ptr_w+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef AT_LATCH_DRAIN_OVFL_EN
    logic ovfl_q, ovfl_d;

    // Sticky drop detection: a strobe arrived while full and nothing left.
    always_comb begin
        ovfl_d = ovfl_q;
        if (e && full && !pop_s) begin
            ovfl_d = 1'b1;
        end else begin
            ovfl_d = ovfl_q;
        end
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovfl_q <= 1'b0;
        end else begin
            ovfl_q <= ovfl_d;
        end
    end

    assign ovfl = ovfl_q;
`else
    assign ovfl = 1'b0;
`endif

endmodule : at_latch_drain

// File: tb/tb_at_latch_drain.sv
// Directed-vector bench for at_latch_drain with hand-computed expectations.
module tb_at_latch_drain;

    logic       clk;
    logic       reset;
    logic       e;
    logic [7:0] d;
    logic       full;
    logic [7:0] q;
    logic       q_valid;
    logic       q_ready;
    logic [2:0] count;
    logic       ovfl;

    int vec_cnt;
    int err_cnt;

`ifdef AT_LATCH_DRAIN_OVFL_EN
    localparam logic OVFL_EXP = 1'b1;
`else
    localparam logic OVFL_EXP = 1'b0;
`endif

    at_latch_drain dut (
        .clk     (clk),
        .reset   (reset),
        .e       (e),
        .d       (d),
        .full    (full),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .count   (count),
        .ovfl    (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    // Inputs change on negedge; one posedge then return to negedge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] w);
        e = 1'b1;
        d = w;
        tick();
        e = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b1;
        e       = 1'b0;
        d       = 8'h00;
        q_ready = 1'b0;
        @(negedge clk);

        tick();
        tick();
        reset = 1'b0;
        check_val("rst_count", 8'(count), 8'd0);
        check_val("rst_qvalid", 8'(q_valid), 8'd0);
        check_val("rst_q", q, 8'h00);
        check_val("rst_full", 8'(full), 8'd0);
        check_val("rst_ovfl", 8'(ovfl), 8'd0);

        push_word(8'hA5);
        check_val("single_qvalid", 8'(q_valid), 8'd1);
        check_val("single_q", q, 8'hA5);
        check_val("single_count", 8'(count), 8'd1);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check_val("single_pop_count", 8'(count), 8'd0);
        check_val("single_pop_qvalid", 8'(q_valid), 8'd0);
        check_val("single_pop_q", q, 8'h00);

        for (int i = 1; i <= 4; i++) push_word(8'(i));
        check_val("fill_full", 8'(full), 8'd1);
        check_val("fill_count", 8'(count), 8'd4);
        check_val("fill_head", q, 8'h01);

        e = 1'b1;
        d = 8'h55;
        q_ready = 1'b1;
        tick();
        e = 1'b0;
        check_val("pp_count", 8'(count), 8'd4);
        check_val("pp_full", 8'(full), 8'd1);
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h55};
        for (int i = 0; i < 4; i++) begin
            check_val("pp_drain", q, exp_seq[i]);
            tick();
        end
        q_ready = 1'b0;
        check_val("pp_empty", 8'(q_valid), 8'd0);

        for (int i = 1; i <= 4; i++) push_word(8'(i));
        e = 1'b1;
        d = 8'hFF;
        tick();
        e = 1'b0;
        check_val("ov_count", 8'(count), 8'd4);
        check_val("ov_flag", 8'(ovfl), 8'(OVFL_EXP));
        tick();
        check_val("ov_sticky", 8'(ovfl), 8'(OVFL_EXP));
        q_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_val("ov_drain", q, 8'(i));
            tick();
        end
        q_ready = 1'b0;
        check_val("ov_empty", 8'(q_valid), 8'd0);
        check_val("ov_after_drain", 8'(ovfl), 8'(OVFL_EXP));

        push_word(8'hA0);
        push_word(8'hA1);
        push_word(8'hA2);
        check_val("mid_count", 8'(count), 8'd3);
        reset   = 1'b1;
        q_ready = 1'b1;
        tick();
        reset   = 1'b0;
        q_ready = 1'b0;
        check_val("mid_rst_count", 8'(count), 8'd0);
        check_val("mid_rst_qvalid", 8'(q_valid), 8'd0);
        check_val("mid_rst_ovfl", 8'(ovfl), 8'd0);

        // Streaming push with ready held high: head lags the input by one cycle.
        q_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = 1'b1;
            d = 8'(8'hB0 + i);
            tick();
            check_val("wrap_q", q, 8'(8'hB0 + i));
            check_val("wrap_count", 8'(count), 8'd1);
        end
        e = 1'b0;
        tick();
        q_ready = 1'b0;
        check_val("wrap_empty", 8'(count), 8'd0);

        for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
        check_val("wrap_fill", 8'(full), 8'd1);
        q_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("wrap_drain", q, 8'(8'hC0 + i));
            tick();
        end
        q_ready = 1'b0;
        check_val("wrap_final", 8'(q_valid), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_at_latch_drain

// File: doc/at_latch_drain.md
Name: at_latch_drain

Overview:
Reader-side counterpart to the enable-strobed capture latch. Words captured with a single-cycle enable strobe are buffered in a small register FIFO. They are then drained to a downstream consumer over a valid/ready handshake. The block sits between an AT capture point and any consumer that cannot accept a word every cycle.

Parameters:
size, 8, data word width in bits.
depth, 4, FIFO entries; power of 2, minimum 2.
ptr_w, 2, log2(depth); pointer width; must be kept consistent with depth.

Ports:
clk  input  1  single clock; all state changes on posedge clk.
reset  input  1  synchronous, active-high reset; sampled on posedge clk.
e  input  1  capture strobe; when high, d is pushed this cycle if accepted.
d  input  size  capture data.
full  output  1  high when count == depth.
q  output  size  head-of-queue data; valid only while q_valid is high.
q_valid  output  1  head word present (count != 0).
q_ready  input  1  consumer accepts q this cycle when q_valid is also high.
count  output  ptr_w+1  number of stored words, 0..depth.
ovfl  output  1  sticky drop flag; see Optional Feature.

Behaviour:
- Reset, synchronous and active-high, takes priority over all other inputs:
  - wr_ptr, rd_ptr, count cleared to 0.
  - full=0, q_valid=0, ovfl=0.
  - Storage contents are not cleared; q is forced to 0 while count==0.
- push = e && (!full || pop).
- pop = q_valid && q_ready.
- Push: mem[wr_ptr] <= d; wr_ptr increments, wrapping at depth (natural ptr_w overflow).
- Pop: rd_ptr increments, wrapping the same way.
- count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop or on neither.
- Output path is first-word-fall-through:
  - q = mem[rd_ptr] combinationally.
  - q_valid = (count != 0), registered via count.
- Latency: word pushed in cycle N is visible on q/q_valid in cycle N+1. There is no same-cycle bypass.
- Empty with push: no pop is possible (q_valid=0). The word is stored and appears in the next cycle.
- Full with push and pop in the same cycle: both take effect. count stays at depth; full stays high.
- Full with push and no pop: d is dropped. State is unchanged apart from ovfl, when compiled in.
- Pop while empty: impossible by definition; q_ready is ignored when q_valid=0.
- q_ready may toggle freely. The consumer may hold q_ready high across cycles, giving one pop per cycle.
- Reset mid-operation discards all buffered words. q_valid is low in the cycle after reset is sampled.
- full and count are registered-derived; no combinational path from e or q_ready to them.
- The only combinational input-to-output path is the storage read via rd_ptr (no dependence on e).

Optional Feature:
- Macro AT_LATCH_DRAIN_OVFL_EN.
- Defined: ovfl is a sticky register, set on any cycle with e && full && !pop. It is cleared only by reset.
- Undefined: ovfl is tied to 0 and no overflow logic is generated. The port is always present so the interface is stable.

Decomposition:
- Shared package at_pkg holds:
  - AT_DATA_W default (8).
  - AT_DRAIN_DEPTH default (4).
  - Pointer-width helper constant.
  - Typedef at_word_t = logic [AT_DATA_W-1:0].
- One natural sub-module: at_drain_mem. It is a depth x size register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata), and has no reset.
- Pointers, count, flags and handshake logic stay in at_latch_drain.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, e=0 -> count=0, q_valid=0, q=0, full=0, ovfl=0.
- Single word: e=1, d=8'hA5 at cycle N, q_ready=0 -> cycle N+1 q_valid=1, q=8'hA5, count=1. Raise q_ready for 1 cycle -> next cycle count=0, q_valid=0.
- Fill and order: push 8'h01..8'h04 on 4 consecutive cycles, q_ready=0 -> full=1, count=4. Drain with q_ready=1 -> q sequence 01,02,03,04, then q_valid=0.
- Full with simultaneous push/pop: at full with head 8'h01, e=1, d=8'h55, q_ready=1 -> count stays 4. Subsequent drain yields 02,03,04,55.
- Overflow (macro defined): at full, e=1, d=8'hFF, q_ready=0 -> count=4, ovfl=1 and stays set. Drain yields 01..04 only, with no 8'hFF. Macro undefined: ovfl=0 throughout.
- Reset mid-drain: 3 words stored, assert reset for 1 cycle while q_ready=1 -> next cycle count=0, q_valid=0. Pointers wrap correctly on the next 6 pushes/pops.
